// File: rtl/gb_mem_pkg.sv
// Shared constants, DMA state type and address helpers for the Game Boy
// memory path in front of the 64 KiB unified memory.
package gb_mem_pkg;

   localparam logic [15:0] DMA_REG_ADR = 16'hFF46;
   localparam logic [15:0] OAM_BASE    = 16'hFE00;
   localparam logic [15:0] HRAM_LO     = 16'hFF80;
   localparam logic [15:0] HRAM_HI     = 16'hFFFE;
   localparam int          OAM_LEN     = 160;

   typedef enum logic [1:0] {
      IDLE,
      START,
      READ,
      WRITE
   } dma_state_t;

   // True for addresses the CPU may still reach while a transfer runs.
   function automatic logic is_hram(input logic [15:0] adr);
      return (adr >= HRAM_LO) && (adr <= HRAM_HI);
   endfunction

endpackage

// File: rtl/oam_dma_if.sv
// CPU-side and memory-side bus of the OAM DMA block. The slave modport is the
// DMA block itself; the master modport is the CPU plus memory around it.
interface oam_dma_if;

   // Strobes are single-cycle and unconditionally accepted: there is no ready.
   // cpu_rdata and mem_rdata are combinational in the same cycle as the strobe.
   logic [15:0] cpu_adr;
   logic        cpu_rd_en;
   logic        cpu_wr_en;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic [15:0] mem_adr;
   logic        mem_wr_en;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   modport master (
      output cpu_adr, cpu_rd_en, cpu_wr_en, cpu_wdata, mem_rdata,
      input  cpu_rdata, mem_adr, mem_wr_en, mem_wdata
   );

   modport slave (
      input  cpu_adr, cpu_rd_en, cpu_wr_en, cpu_wdata, mem_rdata,
      output cpu_rdata, mem_adr, mem_wr_en, mem_wdata
   );

endinterface

// File: rtl/oam_dma.sv
// OAM DMA engine and memory-port arbiter: copies LEN bytes from {src_hi,00}
// to OAM, restricting the CPU to HRAM while the copy runs.
module oam_dma
   import gb_mem_pkg::*;
#(
   parameter int LEN = OAM_LEN
) (
   input  logic       clk,
   input  logic       rst,
   oam_dma_if.slave   bus,
   output logic       dma_active,
   output logic       dma_done,
   output dma_state_t dbg_state
);

   localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

   dma_state_t state;
   logic [7:0] src_hi;
   logic [7:0] idx;
   logic [7:0] byte_q;

   logic reg_wr;
   logic reg_rd;
   logic cpu_hram;
   logic busy;

   assign reg_wr   = bus.cpu_wr_en && (bus.cpu_adr == DMA_REG_ADR);
   assign reg_rd   = bus.cpu_rd_en && (bus.cpu_adr == DMA_REG_ADR);
   assign cpu_hram = (bus.cpu_rd_en || bus.cpu_wr_en) && is_hram(bus.cpu_adr);
   assign busy     = (state == READ) || (state == WRITE);

   assign dma_active = (state != IDLE) && !rst;
   assign dbg_state  = state;

   // An HRAM access steals the port for one cycle; the DMA simply stalls.
   always_comb begin
      bus.mem_adr   = bus.cpu_adr;
      bus.mem_wdata = bus.cpu_wdata;
      bus.mem_wr_en = bus.cpu_wr_en && !reg_wr;
      bus.cpu_rdata = bus.mem_rdata;
      if (busy && !cpu_hram) begin
         bus.mem_adr   = (state == READ) ? {src_hi, idx} : (OAM_BASE | {8'h00, idx});
         bus.mem_wdata = byte_q;
         bus.mem_wr_en = (state == WRITE);
         bus.cpu_rdata = 8'hFF;
      end
      if (reg_rd) bus.cpu_rdata = src_hi;
      if (rst) bus.mem_wr_en = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         src_hi   <= 8'h00;
         idx      <= 8'h00;
         byte_q   <= 8'h00;
         dma_done <= 1'b0;
      end else begin
         dma_done <= 1'b0;
         if (reg_wr) begin
            // A register write restarts from any state, even mid-transfer.
            src_hi <= bus.cpu_wdata;
            idx    <= 8'h00;
            state  <= START;
         end else begin
            case (state)
               IDLE: ;
               START: begin
                  idx   <= 8'h00;
                  state <= READ;
               end
               READ: begin
                  if (!cpu_hram) begin
                     byte_q <= bus.mem_rdata;
                     state  <= WRITE;
                  end
               end
               WRITE: begin
                  if (!cpu_hram) begin
                     if (idx == LAST_IDX) begin
                        state    <= IDLE;
                        dma_done <= 1'b1;
                     end else begin
                        idx   <= idx + 8'd1;
                        state <= READ;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: behavioural 64 KiB memory, per-scenario tasks and an
// expected-OAM queue built from snapshots of the source page.
module tb_oam_dma;
   import gb_mem_pkg::*;

   localparam int LEN = 160;

   logic       clk = 1'b0;
   logic       rst;
   logic       dma_active;
   logic       dma_done;
   dma_state_t dbg_state;

   oam_dma_if bus ();

   oam_dma #(.LEN(LEN)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus.slave),
      .dma_active (dma_active),
      .dma_done   (dma_done),
      .dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:65535];
   logic [7:0] exp_q[$];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int wr_cnt = 0;
   int act_cnt = 0;
   int done_cnt = 0;
   int done_cyc = 0;

   int start_cyc;
   int act0;
   int done0;

   assign bus.mem_rdata = mem[bus.mem_adr];

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (bus.mem_wr_en) begin
         mem[bus.mem_adr] = bus.mem_wdata;
         wr_cnt = wr_cnt + 1;
      end
   end

   always @(negedge clk) begin
      if (dma_active) act_cnt = act_cnt + 1;
      if (dma_done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      bus.cpu_adr   = a;
      bus.cpu_wdata = d;
      bus.cpu_wr_en = 1'b1;
      tick();
      bus.cpu_wr_en = 1'b0;
   endtask

   task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
      bus.cpu_adr   = a;
      bus.cpu_rd_en = 1'b1;
      #2;
      d = bus.cpu_rdata;
      tick();
      bus.cpu_rd_en = 1'b0;
   endtask

   task automatic start_dma(input logic [7:0] page);
      start_cyc = cyc;
      act0      = act_cnt;
      cpu_write(DMA_REG_ADR, page);
   endtask

   // Fill a source page with random bytes and queue the bytes OAM must end with.
   task automatic load_src(input logic [7:0] page);
      exp_q.delete();
      for (int i = 0; i < 256; i++) mem[{page, 8'(i)}] = 8'($urandom);
      for (int i = 0; i < LEN; i++) exp_q.push_back(mem[{page, 8'(i)}]);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while ((dma_active || dbg_state != IDLE) && n < budget) begin
         tick();
         n++;
      end
      tests++;
      if (n >= budget) begin
         fails++;
         $display("FAIL %s_timeout: still active after %0d cycles, required idle", name, budget);
      end
      repeat (5) tick();
   endtask

   task automatic wait_writes(input string name, input int count);
      int w0;
      int n;
      w0 = wr_cnt;
      n = 0;
      while (wr_cnt - w0 < count && n < 1000) begin
         tick();
         n++;
      end
      tests++;
      if (n >= 1000) begin
         fails++;
         $display("FAIL %s_writes: saw %0d writes, required %0d", name, wr_cnt - w0, count);
      end
   endtask

   task automatic check_oam(input string name);
      int bad;
      int first;
      logic [7:0] e;
      logic [7:0] got_first;
      logic [7:0] exp_first;
      bad = 0;
      first = -1;
      got_first = 8'h00;
      exp_first = 8'h00;
      for (int i = 0; i < LEN; i++) begin
         e = exp_q.pop_front();
         if (mem[OAM_BASE + 16'(i)] !== e) begin
            if (first < 0) begin
               first = i;
               got_first = mem[OAM_BASE + 16'(i)];
               exp_first = e;
            end
            bad++;
         end
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL %s_oam: %0d bad bytes, first at idx %0d got %h required %h",
                  name, bad, first, got_first, exp_first);
      end
   endtask

   task automatic test_reset;
      logic [7:0] d;
      rst = 1'b1;
      repeat (3) tick();
      tests++;
      if (dma_active !== 1'b0 || bus.mem_wr_en !== 1'b0 || dma_done !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs: active=%b wr_en=%b done=%b required 0 0 0",
                  dma_active, bus.mem_wr_en, dma_done);
      end
      rst = 1'b0;
      tick();
      tests++;
      if (dbg_state !== IDLE) begin
         fails++;
         $display("FAIL reset_state: got %0d required IDLE", dbg_state);
      end
      cpu_read(DMA_REG_ADR, d);
      tests++;
      if (d !== 8'h00) begin
         fails++;
         $display("FAIL reset_src_hi: got %h required 00", d);
      end
   endtask

   task automatic test_passthrough;
      logic [7:0] d;
      int a0;
      a0 = act_cnt;
      cpu_write(16'hC123, 8'hAB);
      cpu_read(16'hC123, d);
      tests++;
      if (d !== 8'hAB) begin
         fails++;
         $display("FAIL idle_readback: got %h required AB", d);
      end
      tests++;
      if (act_cnt != a0 || dma_active !== 1'b0) begin
         fails++;
         $display("FAIL idle_active: %0d active cycles, required 0", act_cnt - a0);
      end
   endtask

   task automatic test_full_transfer;
      logic [7:0] sentinel;
      exp_q.delete();
      for (int i = 0; i < LEN; i++) begin
         mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
         exp_q.push_back(8'(i) ^ 8'h5A);
      end
      sentinel = 8'($urandom);
      mem[16'hFEA0] = sentinel;
      done0 = done_cnt;
      start_dma(8'hC0);
      wait_idle("full", 1000);
      tests++;
      if (act_cnt - act0 != 2 * LEN + 1) begin
         fails++;
         $display("FAIL full_active: %0d cycles, required %0d", act_cnt - act0, 2 * LEN + 1);
      end
      tests++;
      if (done_cnt - done0 != 1 || done_cyc - start_cyc != 2 * LEN + 2) begin
         fails++;
         $display("FAIL full_done: %0d pulses at +%0d, required 1 at +%0d",
                  done_cnt - done0, done_cyc - start_cyc, 2 * LEN + 2);
      end
      check_oam("full");
      tests++;
      if (mem[16'hFEA0] !== sentinel) begin
         fails++;
         $display("FAIL full_fea0: got %h required %h", mem[16'hFEA0], sentinel);
      end
   endtask

   task automatic test_cpu_during;
      logic [7:0] page;
      logic [7:0] d000_old;
      logic [7:0] d;
      page = 8'($urandom_range(8'hC1, 8'hCF));
      load_src(page);
      d000_old = 8'h33 ^ 8'($urandom_range(1, 255));
      mem[16'hD000] = d000_old;
      done0 = done_cnt;
      start_dma(page);
      repeat ($urandom_range(5, 200)) tick();
      cpu_read(16'hC010, d);
      tests++;
      if (d !== 8'hFF) begin
         fails++;
         $display("FAIL during_read_c010: got %h required FF", d);
      end
      cpu_write(16'hD000, 8'h33);
      cpu_read(DMA_REG_ADR, d);
      tests++;
      if (d !== page) begin
         fails++;
         $display("FAIL during_read_reg: got %h required %h", d, page);
      end
      wait_idle("during", 1000);
      tests++;
      if (mem[16'hD000] !== d000_old) begin
         fails++;
         $display("FAIL during_d000: got %h required %h", mem[16'hD000], d000_old);
      end
      tests++;
      if (done_cnt - done0 != 1) begin
         fails++;
         $display("FAIL during_done: %0d pulses, required 1", done_cnt - done0);
      end
      check_oam("during");
   endtask

   task automatic test_hram;
      logic [7:0] page;
      logic [7:0] d;
      page = 8'($urandom_range(8'h80, 8'hCF));
      load_src(page);
      mem[16'hFF90] = 8'h00;
      done0 = done_cnt;
      start_dma(page);
      repeat ($urandom_range(5, 250)) tick();
      cpu_write(16'hFF90, 8'h77);
      cpu_read(16'hFF90, d);
      tests++;
      if (d !== 8'h77) begin
         fails++;
         $display("FAIL hram_readback: got %h required 77", d);
      end
      wait_idle("hram", 1000);
      tests++;
      if (act_cnt - act0 != 2 * LEN + 3 || done_cyc - start_cyc != 2 * LEN + 4) begin
         fails++;
         $display("FAIL hram_timing: active %0d done +%0d, required %0d and +%0d",
                  act_cnt - act0, done_cyc - start_cyc, 2 * LEN + 3, 2 * LEN + 4);
      end
      check_oam("hram");
   endtask

   task automatic test_restart;
      load_src(8'hC0);
      load_src(8'hD0);
      done0 = done_cnt;
      start_dma(8'hC0);
      wait_writes("restart", 50);
      start_dma(8'hD0);
      wait_idle("restart", 1000);
      tests++;
      if (done_cnt - done0 != 1 || done_cyc - start_cyc != 2 * LEN + 2) begin
         fails++;
         $display("FAIL restart_done: %0d pulses at +%0d, required 1 at +%0d",
                  done_cnt - done0, done_cyc - start_cyc, 2 * LEN + 2);
      end
      check_oam("restart");
   endtask

   task automatic test_reset_mid;
      logic [7:0] page;
      logic [7:0] old [0:LEN-1];
      logic [7:0] d;
      int w_rst;
      int bad;
      page = 8'($urandom_range(8'h80, 8'hCF));
      load_src(page);
      for (int i = 0; i < LEN; i++) begin
         old[i] = 8'($urandom);
         mem[OAM_BASE + 16'(i)] = old[i];
      end
      start_dma(page);
      wait_writes("reset_mid", 20);
      w_rst = wr_cnt;
      rst = 1'b1;
      #1;
      tests++;
      if (bus.mem_wr_en !== 1'b0 || dma_active !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_during: wr_en=%b active=%b required 0 0",
                  bus.mem_wr_en, dma_active);
      end
      tick();
      rst = 1'b0;
      repeat (400) tick();
      tests++;
      if (wr_cnt != w_rst) begin
         fails++;
         $display("FAIL reset_mid_writes: %0d writes after reset, required 0", wr_cnt - w_rst);
      end
      bad = 0;
      for (int i = 20; i < LEN; i++) if (mem[OAM_BASE + 16'(i)] !== old[i]) bad++;
      for (int i = 0; i < 20; i++) if (mem[OAM_BASE + 16'(i)] !== exp_q[i]) bad++;
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL reset_mid_oam: %0d bad bytes, required 0", bad);
      end
      tests++;
      if (dma_active !== 1'b0 || dbg_state !== IDLE) begin
         fails++;
         $display("FAIL reset_mid_idle: active=%b state=%0d required 0 IDLE", dma_active, dbg_state);
      end
      cpu_read(DMA_REG_ADR, d);
      tests++;
      if (d !== 8'h00) begin
         fails++;
         $display("FAIL reset_mid_src_hi: got %h required 00", d);
      end
   endtask

   initial begin
      bus.cpu_adr   = 16'h0000;
      bus.cpu_rd_en = 1'b0;
      bus.cpu_wr_en = 1'b0;
      bus.cpu_wdata = 8'h00;
      rst = 1'b1;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      test_reset();
      test_passthrough();
      test_full_transfer();
      test_cpu_during();
      test_hram();
      test_restart();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sits directly upstream of the 64 KiB unified memory, between the CPU memory port and the memory's adr/data_in/wr_en/data_out pins.
- Owns the DMA source register at 16'hFF46. A CPU write there copies LEN bytes from {src_hi, 8'h00} to OAM at 16'hFE00.
- While a transfer runs, it arbitrates the single memory port and restricts CPU access to HRAM, as the Game Boy OAM DMA does.

Parameters:
- LEN, 160, bytes per transfer; legal range 1..256.
- OAM_BASE, 16'hFE00, destination base; low byte must be 8'h00.
- DMA_REG_ADR, 16'hFF46, address of the DMA source register.
- HRAM_LO, 16'hFF80, lowest address the CPU may access during a transfer.
- HRAM_HI, 16'hFFFE, highest address the CPU may access during a transfer.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cpu_adr  in  16  CPU address.
- cpu_rd_en  in  1  CPU read strobe.
- cpu_wr_en  in  1  CPU write strobe.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  read data returned to the CPU (combinational).
- mem_adr  out  16  to memory adr.
- mem_wr_en  out  1  to memory wr_en.
- mem_wdata  out  8  to memory data_in.
- mem_rdata  in  8  from memory data_out; combinational, same-cycle read.
- dma_active  out  1  high in START, READ and WRITE.
- dma_done  out  1  one-cycle pulse after the final byte is written.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, src_hi=8'h00, idx=0, byte_q=0, dma_done=0.
  - Outputs during reset: mem_wr_en=0, dma_active=0.
  - Reset mid-transfer aborts immediately; no further memory writes occur.
- States: IDLE -> START -> READ <-> WRITE -> IDLE.
  - IDLE: idle until a CPU register write.
  - START: one-cycle delay; no memory access; idx=0.
  - READ: mem_adr={src_hi, idx}, mem_wr_en=0; byte_q<=mem_rdata at posedge.
  - WRITE: mem_adr=OAM_BASE+idx, mem_wdata=byte_q, mem_wr_en=1.
    - If idx==LEN-1: go to IDLE and pulse dma_done on the next cycle.
    - Otherwise: idx<=idx+1, go to READ.
- Timing: a register write sampled at posedge N gives START in cycle N+1, the first READ in N+2, and the last WRITE in N+2+2*LEN-1 (N+321 with LEN=160). dma_active falls and dma_done pulses in N+2+2*LEN.
- Address widths:
  - idx is 8 bits.
  - Source address = {src_hi, idx}; no carry into the high byte, so the source never crosses a 256-byte page.
  - Any src_hi value is accepted unchanged.
- Register access:
  - A CPU write with cpu_adr==DMA_REG_ADR loads src_hi<=cpu_wdata and forces state<=START, idx<=0, in any state.
  - If that write lands in a WRITE cycle, the in-flight byte write still completes that cycle, then the transfer restarts.
  - Register writes are never forwarded to memory (mem_wr_en comes from the DMA only).
  - Reads of DMA_REG_ADR return src_hi at all times.
- CPU pass-through, in IDLE or START:
  - mem_adr=cpu_adr, mem_wdata=cpu_wdata.
  - mem_wr_en=cpu_wr_en, except for register writes.
  - cpu_rdata=mem_rdata.
- CPU access in READ or WRITE:
  - HRAM accesses (cpu_rd_en|cpu_wr_en with HRAM_LO<=cpu_adr<=HRAM_HI): the CPU owns the port that cycle; the DMA holds state, idx and byte_q, and makes no memory write.
  - Non-HRAM reads return 8'hFF (except the register); non-HRAM writes are dropped.
  - With no CPU strobe, the DMA owns the port.
- Simultaneous register write and HRAM access are impossible (single CPU address); no further rule is needed.

Decomposition:
- Package gb_mem_pkg holds:
  - DMA_REG_ADR, OAM_BASE, HRAM_LO, HRAM_HI, OAM_LEN=160;
  - the dma_state_t enum {IDLE, START, READ, WRITE};
  - the function is_hram(adr).
- No sub-module: a single FSM plus port mux. The memory stays a separate instance below this block.

Test Plan:
- Preload 16'hC000..C09F with i^8'h5A; CPU writes 8'hC0 to FF46. Required:
  - dma_active high for exactly 321 cycles;
  - FE00..FE9F match the source;
  - dma_done pulses once, 322 cycles after the write;
  - FEA0 is untouched.
- During the transfer, CPU reads 16'hC010 -> 8'hFF; CPU writes 8'h33 to 16'hD000 -> D000 unchanged after the transfer; read FF46 -> 8'hC0.
- During the transfer, CPU writes 8'h77 to FF90 then reads it back -> 8'h77. The transfer completion time extends by exactly 2 cycles, and OAM contents are still correct.
- Start with src 8'hC0; after 50 bytes, write 8'hD0 to FF46. Required: OAM ends equal to D000..D09F; dma_done pulses once, at the end of the restarted transfer.
- Assert rst for one cycle mid-transfer (idx=20). Required:
  - no mem_wr_en afterwards; FE14..FE9F keep their old values;
  - dma_active=0; FF46 reads 8'h00.
- In IDLE, CPU writes 8'hAB to 16'hC123 and reads it back -> 8'hAB; dma_active stays 0.
